dmem_port_arbiter: RTL

//  - Shares the single-port data memory (16 x 8) between two requesters.

---
 rtl/dmem_port_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//
// Purpose:
//   Shares the single-port 16 x 8 data memory between two requesters:
//   requester 0 is the multicycle CPU (MemREAD/MemWRITE states of the control
//   FSM), requester 1 is the host/debug loader. Accesses are serialised
//   through a three-state FSM (IDLE -> ISSUE -> RESP). Read data goes back to
//   the owning requester together with a one-cycle ack pulse. cpu_stall holds
//   the control FSM in its Mem state until the CPU access completes.
//
// Ports:
//   clock                         system clock, all logic on posedge
//   reset                         synchronous, active-low reset
//   cpu_req/we/addr/wdata         CPU request (held until cpu_ack)
//   cpu_rdata, cpu_ack            CPU response (rdata held after ack)
//   cpu_stall                     cpu_req & ~cpu_ack
//   host_req/we/addr/wdata        host request (held until host_ack)
//   host_rdata, host_ack          host response (rdata held after ack)
//   host_lock                     only with DMEM_ARB_LOCK_EN: blocks CPU grants
//   mem_addr, mem_we, mem_wdata   registered memory command
//   mem_rdata                     memory read data, 1 cycle after mem_addr
//
// Configuration:
//   DMEM_ARB_LOCK_EN  when defined, adds host_lock. While it is high the CPU
//                     is never granted. Undefined gives pure round-robin.
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              host_lock,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic CPU  = 1'b0;
  localparam logic HOST = 1'b1;

  state_t state;
  logic   owner;
  logic   last_grant;
  logic   op_we;
  logic   cpu_eligible;
  logic   any_req;
  logic   grant_host;

  // The lock removes the CPU from arbitration entirely. Its request stays
  // pending, so cpu_stall remains high.
`ifdef DMEM_ARB_LOCK_EN
  assign cpu_eligible = cpu_req & ~host_lock;
`else
  assign cpu_eligible = cpu_req;
`endif

  assign any_req   = cpu_eligible | host_req;
  assign cpu_stall = cpu_req & ~cpu_ack;

  // A lone request wins outright. On a tie, the requester that was not
  // served last wins. last_grant resets to HOST, so the first tie goes to
  // the CPU.
  always_comb begin
    grant_host = 1'b0;
    if (host_req && !cpu_eligible)
      grant_host = 1'b1;
    else if (host_req && cpu_eligible)
      grant_host = (last_grant == CPU);
  end

  // Single FSM with registered memory command and responses. The ack
  // registers default low every cycle, so RESP produces exactly one pulse.
  // A reset that lands while in ISSUE still lets the memory commit a
  // strobed write, because mem_we is high during that cycle. No ack is sent.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= CPU;
      last_grant <= HOST;
      op_we      <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      host_rdata <= '0;
      cpu_ack    <= 1'b0;
      host_ack   <= 1'b0;
    end else begin
      cpu_ack  <= 1'b0;
      host_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner <= grant_host;
            if (grant_host) begin
              mem_we    <= host_we;
              mem_addr  <= host_addr;
              mem_wdata <= host_wdata;
              op_we     <= host_we;
            end else begin
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              op_we     <= cpu_we;
            end
            state <= ISSUE;
          end else begin
            mem_we <= 1'b0;
          end
        end
        ISSUE: begin
          mem_we <= 1'b0;
          state  <= RESP;
        end
        RESP: begin
          if (owner == HOST) begin
            host_ack <= 1'b1;
            if (!op_we)
              host_rdata <= mem_rdata;
          end else begin
            cpu_ack <= 1'b1;
            if (!op_we)
              cpu_rdata <= mem_rdata;
          end
          last_grant <= owner;
          state      <= IDLE;
        end
        default: begin
          mem_we <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
